// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and latency constants for alu_seq
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10,
        OP_DIVU = 4'd11,
        OP_REMU = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter wide enough for the divider latency at WIDTH=64.
    localparam int CNT_W      = 8;
    localparam int SINGLE_LAT = 1;

    function automatic int div_latency(input int width);
        return width + 1;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_divu.sv
// rtl/alu_divu.sv - restoring unsigned divider, one quotient bit per cycle
module alu_divu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] src_rem, src_quo, src_dsr;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] step_rem, step_quo;

    // The first step runs straight off the inputs on the start cycle.
    always_comb begin
        src_rem  = start ? '0       : rem_q;
        src_quo  = start ? dividend : quo_q;
        src_dsr  = start ? divisor  : dsr_q;
        shifted  = {src_rem, src_quo[WIDTH-1]};
        ge       = shifted >= {1'b0, src_dsr};
        diff     = shifted[WIDTH-1:0] - src_dsr;
        step_rem = ge ? diff : shifted[WIDTH-1:0];
        step_quo = {src_quo[WIDTH-2:0], ge};
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            rem_d = step_rem;
            quo_d = step_quo;
            dsr_d = divisor;
            cnt_d = CW'(WIDTH - 1);
        end else if (cnt_q != '0) begin
            rem_d  = step_rem;
            quo_d  = step_quo;
            cnt_d  = cnt_q - 1'b1;
            done_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshake, multi-cycle MUL and DIVU/REMU
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             dz
);

    localparam int SH_W     = $clog2(WIDTH);
    // Counter holds BUSY for (latency - 2) cycles after the first BUSY cycle.
    localparam int DIV_LOAD = div_latency(WIDTH) - 2;
    localparam int MUL_LOAD = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             dz_q, dz_d;
    logic [3:0]       op_q, op_d;

    logic             accept;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] div_quo, div_rem;
    logic             div_done;

    assign accept = in_valid && in_ready;
    assign shamt  = b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
            OP_MUL:  alu_res = a * b;
            default: alu_res = '0;
        endcase
    end

    alu_divu #(.WIDTH(WIDTH)) u_divu (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && is_div(op)),
        .dividend  (a),
        .divisor   (b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_div(op) || (op == OP_MUL && MUL_LAT > 1)) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !rst && (state_q == ST_IDLE);
        out_valid = !rst && (state_q == ST_DONE);
        result    = rst ? '0 : result_q;
        dz        = rst ? 1'b0 : dz_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        result_d = result_q;
        dz_d     = dz_q;
        op_d     = op_q;
        if (accept) begin
            op_d     = op;
            result_d = alu_res;
            dz_d     = is_div(op) && (b == '0);
            cnt_d    = is_div(op) ? CNT_W'(DIV_LOAD) :
                       (op == OP_MUL) ? CNT_W'(MUL_LOAD) : '0;
        end else if (state_q == ST_BUSY && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        // The divider finishes on the last BUSY cycle; capture it here.
        if (div_done) begin
            result_d = (op_q == OP_REMU) ? div_rem : div_quo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
            op_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dz_q     <= dz_d;
            op_q     <= op_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at 32/3 and 8/1 configurations
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        rst;
    int          sel;
    logic        iv, ordy;
    logic [3:0]  op_t;
    logic [63:0] a_t, b_t;

    logic        iv32, iv8, or32, or8, ir32, ir8, ov32, ov8, dz32, dz8;
    logic [31:0] res32;
    logic [7:0]  res8;
    logic        rdy, ov, dzv;
    logic [63:0] res;

    assign iv32 = (sel == 0) && iv;
    assign iv8  = (sel == 1) && iv;
    assign or32 = (sel == 0) && ordy;
    assign or8  = (sel == 1) && ordy;
    assign rdy  = (sel == 1) ? ir8 : ir32;
    assign ov   = (sel == 1) ? ov8 : ov32;
    assign dzv  = (sel == 1) ? dz8 : dz32;
    assign res  = (sel == 1) ? {56'd0, res8} : {32'd0, res32};

    alu_seq #(.WIDTH(32), .MUL_LAT(3)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op(op_t),
        .a(a_t[31:0]), .b(b_t[31:0]), .out_valid(ov32), .out_ready(or32),
        .result(res32), .dz(dz32)
    );

    alu_seq #(.WIDTH(8), .MUL_LAT(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op_t),
        .a(a_t[7:0]), .b(b_t[7:0]), .out_valid(ov8), .out_ready(or8),
        .result(res8), .dz(dz8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (sel=%0d): observed %0h expected %0h", tag, sel, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on 64-bit values, masked to the width.
    function automatic void model(input int w, input int ml, input logic [3:0] op,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic d, output int lat);
        logic [63:0] mask;
        longint      sa, sb;
        int          sh;
        mask = (64'd1 << w) - 64'd1;
        sa   = $signed(a << (64 - w)) >>> (64 - w);
        sb   = $signed(b << (64 - w)) >>> (64 - w);
        sh   = int'(b % 64'(w));
        case (op)
            OP_ADD:  r = (a + b) & mask;
            OP_SUB:  r = (a - b) & mask;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = (sa < sb) ? 64'd1 : 64'd0;
            OP_SLTU: r = (a < b) ? 64'd1 : 64'd0;
            OP_SLL:  r = (a << sh) & mask;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = 64'(sa >>> sh) & mask;
            OP_MUL:  r = (a * b) & mask;
            OP_DIVU: r = (b == 0) ? mask : a / b;
            OP_REMU: r = (b == 0) ? a : a % b;
            default: r = 64'd0;
        endcase
        d   = (op == OP_DIVU || op == OP_REMU) && (b == 0);
        lat = (op == OP_DIVU || op == OP_REMU) ? w + 1 : (op == OP_MUL) ? ml : 1;
    endfunction

    task automatic accept(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int k;
        @(negedge clk);
        op_t = op; a_t = a; b_t = b; iv = 1'b1;
        k = 0;
        while (!rdy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_at_accept", rdy, 1);
        @(posedge clk);
        #1;
        iv   = 1'b0;
        op_t = 4'($urandom);
        a_t  = {$urandom, $urandom};
        b_t  = {$urandom, $urandom};
    endtask

    task automatic run_op(input logic [3:0] op, input logic [63:0] a_in, input logic [63:0] b_in,
                          input int hold, input bit pulse);
        logic [63:0] er, mask, a, b;
        logic        ed;
        int          el, k, w, ml;
        w    = (sel == 1) ? 8 : 32;
        ml   = (sel == 1) ? 1 : 3;
        mask = (64'd1 << w) - 64'd1;
        a    = a_in & mask;
        b    = b_in & mask;
        model(w, ml, op, a, b, er, ed, el);
        accept(op, a, b);
        k = 0;
        do begin
            ordy = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end while (!ov && k < 200);
        ordy = 1'b0;
        chk("latency", k, el);
        chk("result", res, er);
        chk("dz", dzv, ed);
        for (int i = 0; i < hold; i++) begin
            iv = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            chk("held_valid", ov, 1);
            chk("held_result", res, er);
            chk("held_in_ready", rdy, 0);
        end
        iv   = 1'b0;
        ordy = 1'b1;
        chk("in_ready_handshake", rdy, 0);
        @(posedge clk);
        #1;
        ordy = 1'b0;
        @(negedge clk);
        chk("valid_after_take", ov, 0);
        chk("in_ready_after_take", rdy, 1);
    endtask

    task automatic reset_mid(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                             input int cyc);
        int seen;
        accept(op, a, b);
        repeat (cyc) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", ov, 0);
        chk("rst_in_ready", rdy, 0);
        chk("rst_result", res, 0);
        chk("rst_dz", dzv, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", rdy, 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov) seen++;
        end
        chk("no_stale_result", seen, 0);
        run_op(OP_ADD, 64'h1234_5678, 64'h0000_1111, 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  rop;
        logic [63:0] ra, rb;
        rst = 1'b1; sel = 0; iv = 1'b0; ordy = 1'b0;
        op_t = '0; a_t = '0; b_t = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("reset_in_ready", rdy, 0);
            chk("reset_valid", ov, 0);
            chk("reset_result", res, 0);
            chk("reset_dz", dzv, 0);
        end
        sel = 0;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_post_reset32", ir32, 1);
        chk("in_ready_post_reset8", ir8, 1);

        run_op(OP_ADD,  64'hFFFF_FFFF, 64'd1, 0, 0);
        run_op(OP_SRA,  64'h8000_0000, 64'h24, 2, 0);
        run_op(OP_MUL,  64'h0001_0000, 64'h0001_0001, 0, 0);
        run_op(OP_DIVU, 64'd100, 64'd7, 1, 0);
        run_op(OP_REMU, 64'd100, 64'd7, 0, 0);
        run_op(OP_DIVU, 64'd5, 64'd0, 0, 0);
        run_op(OP_REMU, 64'd5, 64'd0, 0, 0);
        run_op(OP_XOR,  64'hDEAD_BEEF, 64'h0F0F_0F0F, 10, 1);
        run_op(4'd13,   64'h1234, 64'h5678, 0, 0);
        run_op(OP_SLT,  64'hFFFF_FFFF, 64'd1, 0, 0);
        run_op(OP_SLTU, 64'hFFFF_FFFF, 64'd1, 0, 0);

        repeat (40) begin
            rop = 4'($urandom_range(0, 15));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if ((rop == OP_DIVU || rop == OP_REMU) && $urandom_range(0, 3) == 0) rb = 0;
            run_op(rop, ra, rb, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        reset_mid(OP_DIVU, 64'd1234, 64'd5, 9);
        reset_mid(OP_ADD, 64'd1, 64'd2, 3);

        sel = 1;
        @(negedge clk);
        run_op(OP_ADD,  64'hFF, 64'd1, 0, 0);
        run_op(OP_MUL,  64'h13, 64'h11, 1, 0);
        run_op(OP_DIVU, 64'd100, 64'd7, 0, 0);
        run_op(OP_REMU, 64'd100, 64'd7, 0, 0);
        run_op(OP_DIVU, 64'd5, 64'd0, 0, 0);
        run_op(OP_SRA,  64'h80, 64'h0B, 0, 0);
        repeat (25) begin
            rop = 4'($urandom_range(0, 15));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if ((rop == OP_DIVU || rop == OP_REMU) && $urandom_range(0, 3) == 0) rb = 0;
            run_op(rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        reset_mid(OP_DIVU, 64'd200, 64'd3, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
